// File: rtl/log2_share_arbiter.sv
// log2_share_arbiter: round-robin share of one Log2_pipe among NUM_REQ requesters, with done watchdog
//   clock, reset(active-low async) | req/req_in: per-requester level request + 32-bit operand
//   ack/err/exponent_out/fraction_out: one-hot result pulse, timeout flag, latched result
//   busy: not IDLE | log2_start/log2_in -> Log2_pipe | log2_done/log2_exponent/log2_fraction <- Log2_pipe
module log2_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_in,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    err,
    output logic [15:0]             exponent_out,
    output logic [15:0]             fraction_out,
    output logic                    busy,
    output logic                    log2_start,
    output logic [31:0]             log2_in,
    input  logic                    log2_done,
    input  logic [15:0]             log2_exponent,
    input  logic [15:0]             log2_fraction
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;
    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] id;
    logic [PW-1:0] gnt;
    logic          found;
    logic [15:0]   wd;
    // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        gnt   = ptr;
        found = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                gnt   = PW'((int'(ptr) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= PW'(NUM_REQ - 1);
            id           <= '0;
            wd           <= '0;
            ack          <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            log2_start   <= 1'b0;
            log2_in      <= '0;
            exponent_out <= '0;
            fraction_out <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    id         <= gnt;
                    ptr        <= gnt;
                    log2_in    <= req_in[32*int'(gnt) +: 32];
                    log2_start <= 1'b1;
                    busy       <= 1'b1;
                    state      <= START;
                end
                START: begin
                    log2_start <= 1'b0;
                    wd         <= '0;
                    state      <= WAIT;
                end
                WAIT: if (log2_done) begin
                    exponent_out <= log2_exponent;
                    fraction_out <= log2_fraction;
                    err          <= 1'b0;
                    ack          <= NUM_REQ'(1) << id;
                    state        <= ACK;
                end else if (wd >= 16'(TIMEOUT)) begin
                    exponent_out <= '0;
                    fraction_out <= '0;
                    err          <= 1'b1;
                    ack          <= NUM_REQ'(1) << id;
                    state        <= ACK;
                end else if (wd != 16'hFFFF) begin
                    wd <= wd + 16'd1;
                end
                ACK: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
